// File: rtl/ctl_ff_sequencer_if.sv
// Signal bundle between control logic and the flip-flop word-timing sequencer.
// The master drives requests and strobes; the slave is the sequencer itself.
interface ctl_ff_sequencer_if #(
  parameter int NFF   = 8,
  parameter int BPW   = 29,
  parameter int WORDS = 108
);
  localparam int BW = $clog2(BPW);
  localparam int WW = $clog2(WORDS);

  logic           enable;
  logic           hold;
  logic [NFF-1:0] set_req;
  logic [NFF-1:0] clr_req;
  logic           conflict_clr;
  logic [BW-1:0]  bit_time;
  logic [WW-1:0]  word_time;
  logic           t0;
  logic           t28;
  logic [NFF-1:0] ff_s;
  logic [NFF-1:0] ff_r;
  logic [NFF-1:0] conflict;
  logic           halted;

  modport master (
    output enable, hold, set_req, clr_req, conflict_clr,
    input  bit_time, word_time, t0, t28, ff_s, ff_r, conflict, halted
  );

  modport slave (
    input  enable, hold, set_req, clr_req, conflict_clr,
    output bit_time, word_time, t0, t28, ff_s, ff_r, conflict, halted
  );
endinterface

// File: rtl/ctl_ff_sequencer.sv
// Word-timing sequencer: bit/word time counters plus collection of set/clear
// requests that are issued as one-cycle s/r strobes only at word boundaries.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_SYNC | first cycle after reset; counters held, requests latched
//  ST_RUN  | counters advance on enable; requests applied at T28 edges
//  ST_HALT | stopped at a word boundary; counters frozen, requests latched
module ctl_ff_sequencer #(
  parameter int NFF   = 8,
  parameter int BPW   = 29,
  parameter int WORDS = 108
) (
  input logic               clk,
  input logic               rst_n,
  ctl_ff_sequencer_if.slave bus
);
  localparam int BW = $clog2(BPW);
  localparam int WW = $clog2(WORDS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BPW - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [BW-1:0]  bit_q;
  logic [WW-1:0]  word_q;
  logic [NFF-1:0] pend_set;
  logic [NFF-1:0] pend_clr;
  logic [NFF-1:0] eff_set;
  logic [NFF-1:0] eff_clr;
  logic [NFF-1:0] new_conf;
  logic [NFF-1:0] ff_s_q;
  logic [NFF-1:0] ff_r_q;
  logic [NFF-1:0] conflict_q;
  logic           running;
  logic           step;
  logic           apply;

  always_comb begin
    state_nxt = state;
    running   = (state == ST_RUN);
    step      = running && bus.enable;
    apply     = step && (bit_q == BIT_LAST);
    eff_set   = pend_set | bus.set_req;
    eff_clr   = pend_clr | bus.clr_req;
    new_conf  = apply ? (eff_set & eff_clr) : '0;
    case (state)
      ST_SYNC: state_nxt = ST_RUN;
      ST_RUN:  if (apply && bus.hold) state_nxt = ST_HALT;
      ST_HALT: if (!bus.hold) state_nxt = ST_RUN;
      default: state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q  <= '0;
      word_q <= '0;
    end else if (step) begin
      if (bit_q == BIT_LAST) begin
        bit_q  <= '0;
        word_q <= (word_q == WORD_LAST) ? '0 : word_q + 1'b1;
      end else begin
        bit_q <= bit_q + 1'b1;
      end
    end
  end

  // Clear wins over set so s and r can never both reach one flip-flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_s_q   <= '0;
      ff_r_q   <= '0;
      pend_set <= '0;
      pend_clr <= '0;
    end else if (apply) begin
      ff_s_q   <= eff_set & ~eff_clr;
      ff_r_q   <= eff_clr;
      pend_set <= '0;
      pend_clr <= '0;
    end else begin
      ff_s_q   <= '0;
      ff_r_q   <= '0;
      pend_set <= eff_set;
      pend_clr <= eff_clr;
    end
  end

  // A conflict raised at the same edge as conflict_clr survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                conflict_q <= '0;
    else if (bus.conflict_clr) conflict_q <= new_conf;
    else                       conflict_q <= conflict_q | new_conf;
  end

  assign bus.bit_time  = bit_q;
  assign bus.word_time = word_q;
  assign bus.t0        = running && (bit_q == '0);
  assign bus.t28       = running && (bit_q == BIT_LAST);
  assign bus.ff_s      = ff_s_q;
  assign bus.ff_r      = ff_r_q;
  assign bus.conflict  = conflict_q;
  assign bus.halted    = (state == ST_HALT);
endmodule
